// File: rtl/rggen_bit_field_rwk_if.sv
// Register-side access bundle seen by one rggen bit field.
// write_access() is true for a write transfer; plain reads leave field state untouched.
interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  write;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] read_data;

    function automatic logic write_access();
        return valid && write;
    endfunction

    modport data (
        input  valid, write, write_data, write_mask,
        output read_data,
        import write_access
    );

    modport host (
        output valid, write, write_data, write_mask,
        input  read_data,
        import write_access
    );
endinterface

// File: rtl/rggen_bit_field_rwk.sv
// Key-protected read/write bit field: KEY_COUNT key writes unlock exactly one data write.
// Optional macro RGGEN_RWK_TIMEOUT_EN discards idle unlock progress after TIMEOUT cycles.
module rggen_bit_field_rwk #(
    parameter int                                 MSB           = 0,
    parameter int                                 LSB           = 0,
    parameter logic [MSB-LSB:0]                   INITIAL_VALUE = '0,
    parameter int                                 KEY_COUNT     = 2,
    parameter logic [KEY_COUNT-1:0][MSB-LSB:0]    KEY_VALUES    = '0,
    parameter int                                 TIMEOUT       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_lock,
    rggen_register_if.data        register_if,
    output logic [MSB-LSB:0]      o_value,
    output logic                  o_unlocked,
    output logic                  o_key_error
);
    localparam int                 WIDTH    = MSB - LSB + 1;
    localparam int                 IDX_W    = (KEY_COUNT > 1) ? $clog2(KEY_COUNT) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(KEY_COUNT - 1);

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               key_error_q, key_error_d;

    logic               wr;
    logic [WIDTH-1:0]   field_data;
    logic [WIDTH-1:0]   field_mask;
    logic               key_match;
    logic               timer_expire;
    logic [31:0]        read_data;

    assign wr         = register_if.write_access();
    assign field_data = register_if.write_data[MSB:LSB];
    assign field_mask = register_if.write_mask[MSB:LSB];
    // A key only counts when every field bit is written; partial masks are wrong keys.
    assign key_match  = wr && (&field_mask) && (field_data == KEY_VALUES[idx_q]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        value_d     = value_q;
        key_error_d = 1'b0;
        if (i_lock) begin
            state_d = LOCKED;
            idx_d   = '0;
        end else if (wr) begin
            case (state_q)
                LOCKED: begin
                    if (key_match) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = UNLOCKED;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        idx_d       = '0;
                        key_error_d = 1'b1;
                    end
                end
                UNLOCKED: begin
                    value_d = (value_q & ~field_mask) | (field_data & field_mask);
                    state_d = LOCKED;
                    idx_d   = '0;
                end
                default: begin
                    state_d = LOCKED;
                    idx_d   = '0;
                end
            endcase
        end else if (timer_expire) begin
            state_d = LOCKED;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOCKED;
            idx_q       <= '0;
            value_q     <= INITIAL_VALUE;
            key_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            key_error_q <= key_error_d;
        end
    end

`ifdef RGGEN_RWK_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        progress_active;

    assign progress_active = (state_q == UNLOCKED) || (idx_q != '0);
    // Expiry happens on the edge where the counter would step from 1 to 0.
    assign timer_expire    = !i_lock && !wr && progress_active && (timer_q <= 16'd1);

    always_comb begin
        timer_d = timer_q;
        if (i_lock) begin
            timer_d = '0;
        end else if (wr) begin
            timer_d = (key_match && state_q == LOCKED) ? 16'(TIMEOUT) : 16'd0;
        end else if (progress_active) begin
            timer_d = (timer_q <= 16'd1) ? 16'd0 : timer_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout;
    assign timer_expire   = 1'b0;
    assign unused_timeout = ^16'(TIMEOUT);
`endif

    always_comb begin
        read_data          = '0;
        read_data[MSB:LSB] = value_q;
    end

    logic unused_bits;
    assign unused_bits = ^{register_if.write_data, register_if.write_mask};

    assign register_if.read_data = read_data;
    assign o_value               = value_q;
    assign o_unlocked            = (state_q == UNLOCKED);
    assign o_key_error           = key_error_q;
endmodule

// File: tb/tb_rggen_bit_field_rwk.sv
// Scoreboard bench for rggen_bit_field_rwk: directed scenarios plus random traffic checked
// against a progress-count model of the unlock protocol.
module tb_rggen_bit_field_rwk;
    localparam int         KEY_COUNT = 2;
    localparam int         TIMEOUT   = 8;
    localparam logic [7:0] INIT      = 8'h3C;
    localparam int         W         = 18;

    logic clk;
    logic rst;
    logic i_lock;
    logic [7:0] dut_value;
    logic dut_unlocked;
    logic dut_key_error;

    rggen_register_if #(.DATA_WIDTH(32)) reg_if ();

    rggen_bit_field_rwk #(
        .MSB           (7),
        .LSB           (0),
        .INITIAL_VALUE (INIT),
        .KEY_COUNT     (KEY_COUNT),
        .KEY_VALUES    ({8'hA5, 8'h5A}),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_lock      (i_lock),
        .register_if (reg_if),
        .o_value     (dut_value),
        .o_unlocked  (dut_unlocked),
        .o_key_error (dut_key_error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: progress = number of correct keys so far, KEY_COUNT means unlocked
    logic [7:0] keys [KEY_COUNT];
    int         progress;
    int         timer;
    logic [7:0] m_value;
    logic       m_err;
    bit         timeout_en;

    logic [W-1:0] exp_q[$];
    int checks;
    int passes;
    int step_no;

    function automatic logic [W-1:0] expected_now();
        return {m_value, (progress == KEY_COUNT) ? 1'b1 : 1'b0, m_err, m_value};
    endfunction

    task automatic model_reset();
        progress = 0;
        timer    = 0;
        m_value  = INIT;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic lock, input logic is_write,
                              input logic [7:0] data, input logic [7:0] mask);
        m_err = 1'b0;
        if (lock) begin
            progress = 0;
            timer    = 0;
        end else if (is_write) begin
            if (progress == KEY_COUNT) begin
                m_value  = (m_value & ~mask) | (data & mask);
                progress = 0;
                timer    = 0;
            end else if (mask == 8'hFF && data == keys[progress]) begin
                progress = progress + 1;
                timer    = TIMEOUT;
            end else begin
                progress = 0;
                timer    = 0;
                m_err    = 1'b1;
            end
        end else if (timeout_en && progress > 0) begin
            timer = timer - 1;
            if (timer <= 0) begin
                timer    = 0;
                progress = 0;
            end
        end
    endtask

    // driver tasks: inputs change just after the falling edge
    task automatic step(input logic lock, input logic valid, input logic write,
                        input logic [31:0] data, input logic [31:0] mask);
        @(negedge clk);
        #1;
        rst               = 1'b0;
        i_lock            = lock;
        reg_if.valid      = valid;
        reg_if.write      = write;
        reg_if.write_data = data;
        reg_if.write_mask = mask;
        model_step(lock, valid && write, data[7:0], mask[7:0]);
        exp_q.push_back(expected_now());
    endtask

    task automatic wr(input logic [7:0] data, input logic [7:0] mask);
        step(1'b0, 1'b1, 1'b1, {$urandom_range(0, 255), 16'h0, data}, {24'hFFFFFF, mask});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst          = 1'b1;
        i_lock       = 1'b0;
        reg_if.valid = 1'b0;
        reg_if.write = 1'b0;
        model_reset();
        exp_q.push_back(expected_now());
    endtask

    task automatic unlock();
        wr(8'h5A, 8'hFF);
        wr(8'hA5, 8'hFF);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp;
            logic [W-1:0] act;
            exp = exp_q.pop_front();
            act = {dut_value, dut_unlocked, dut_key_error, reg_if.read_data[7:0]};
            step_no = step_no + 1;
            checks  = checks + 1;
            if (act === exp) begin
                passes = passes + 1;
            end else begin
                $display("FAIL scoreboard step %0d: got value=%h unlocked=%b key_error=%b read=%h, expected value=%h unlocked=%b key_error=%b read=%h",
                         step_no, act[17:10], act[9], act[8], act[7:0],
                         exp[17:10], exp[9], exp[8], exp[7:0]);
            end
        end
    end

    initial begin
        keys[0]    = 8'h5A;
        keys[1]    = 8'hA5;
`ifdef RGGEN_RWK_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        checks  = 0;
        passes  = 0;
        step_no = 0;
        rst               = 1'b1;
        i_lock            = 1'b0;
        reg_if.valid      = 1'b0;
        reg_if.write      = 1'b0;
        reg_if.write_data = '0;
        reg_if.write_mask = '0;
        model_reset();

        do_reset();
        idle();
        // write without keys
        wr(8'hFF, 8'hFF);
        idle();
        // full unlock, data write, then a locked write
        unlock();
        wr(8'h12, 8'hFF);
        wr(8'h34, 8'hFF);
        idle();
        // broken key sequence
        wr(8'h5A, 8'hFF);
        wr(8'h00, 8'hFF);
        wr(8'hA5, 8'hFF);
        idle();
        // masked data write from the initial value
        do_reset();
        unlock();
        wr(8'hF0, 8'h0F);
        // partial-mask key is a wrong key
        wr(8'h5A, 8'h0F);
        // i_lock beats a same-cycle data write
        do_reset();
        unlock();
        step(1'b1, 1'b1, 1'b1, 32'h77, 32'hFF);
        idle();
        // i_lock mid-sequence discards progress
        wr(8'h5A, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(8'hA5, 8'hFF);
        // reset mid-sequence
        wr(8'h5A, 8'hFF);
        do_reset();
        wr(8'hA5, 8'hFF);
        // reads do not consume the unlock; zero-mask write does
        unlock();
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'hFF);
        wr(8'h55, 8'h00);
        wr(8'h55, 8'hFF);
        // idle behaviour while unlocked
        unlock();
        for (int i = 0; i < 100; i++) idle();
        wr(8'h99, 8'hFF);
        idle();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic       lk;
            int         kind;
            logic [7:0] d;
            logic [7:0] m;
            lk   = ($urandom_range(0, 99) < 4);
            kind = $urandom_range(0, 9);
            if (progress < KEY_COUNT && $urandom_range(0, 9) < 6) d = keys[progress];
            else d = 8'($urandom_range(0, 255));
            m = ($urandom_range(0, 9) < 8) ? 8'hFF : 8'($urandom_range(0, 255));
            if (kind < 2) step(lk, 1'b0, 1'b0, 32'h0, 32'h0);
            else if (kind == 2) step(lk, 1'b1, 1'b0, {24'h0, d}, {24'h0, m});
            else step(lk, 1'b1, 1'b1, {24'h0, d}, {24'h0, m});
        end

        repeat (3) @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            passes = passes + 1;
        end else begin
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
